signdet_post_vote: RTL and testbench
====================================

Name: signdet_post_vote

Overview:
- Parametrised post-processor for the sign/gesture classifier output stream.
- Consumes one score per class per frame and tracks the top-2 scores and their indices.
- Computes the top-1/top-2 margin and gates it against a runtime confidence threshold.
- Applies N-frame temporal voting so the gesture index sent to the host/LED logic only changes after consistent, confident detections.

Parameters:
- DW, 16, score width in bits.
- NCLS, 8, classes per frame; must be <= 2**IW - 1.
- IW, 4, index width; all-ones (2**IW-1) is the invalid index.
- SIGNED_CMP, 0:
  - 0: unsigned compare; scores with MSB set are ignored.
  - 1: two's-complement compare; all scores are eligible.
- HOLD_N, 3, consecutive agreeing confident frames required to update the stable index (>=1).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- i_init  in  1  frame start pulse; clears trackers
- i_we  in  1  score valid strobe
- i_dout  in  DW  class score, class index = beat order within frame
- i_conf_th  in  DW  unsigned margin threshold, sampled at evaluation
- o_diff  out  DW  top1 - top2 margin, unsigned, saturating
- o_max_idx  out  IW  top-1 index of last frame
- o_2nd_idx  out  IW  top-2 index of last frame
- o_conf  out  1  o_diff >= i_conf_th and o_max_idx valid
- o_validp  out  1  one-cycle pulse: frame outputs updated
- o_stable_idx  out  IW  voted gesture index
- o_stable_chg  out  1  one-cycle pulse when o_stable_idx changes
- o_abort  out  1  one-cycle pulse: frame restarted before NCLS beats

Behaviour:
- Reset values:
  - o_diff = 0; o_conf, o_validp, o_stable_chg, o_abort = 0.
  - All index outputs = invalid (all-ones).
  - FSM in IDLE; vote run counter = 0.
- FSM IDLE -> ACC on i_init. ACC -> EVAL on the cycle the NCLS-th accepted beat is registered. EVAL -> OUT -> IDLE unconditionally.
- Beats are accepted only in ACC (i_we=1). i_we in IDLE/EVAL/OUT is ignored. Beats need not be contiguous.
- i_init in ACC:
  - Clears trackers and the beat count; FSM stays in ACC.
  - If the beat count was >0, pulse o_abort the next cycle and do not emit o_validp.
  - i_init has priority over a simultaneous i_we; that beat is dropped.
- i_init in EVAL/OUT: completes the current frame's outputs, then enters ACC with cleared trackers (accepted in the same cycle; not lost).
- Tracker update per accepted beat (v = score, k = beat index):
  - If v > max1: max2 <- max1, idx2 <- idx1, max1 <- v, idx1 <- k.
  - Else if v > max2: max2 <- v, idx2 <- k.
  - Strict compares, so the earliest index wins ties. A value equal to max1 lands in max2, giving margin 0.
- Tracker init values:
  - SIGNED_CMP=0: 0.
  - SIGNED_CMP=1: most-negative value.
  - Both cases: indices = invalid.
- Evaluation (EVAL): diff computed in DW+1 bits as max1 - max2 (signed or unsigned per mode).
  - Saturate to 2**DW-1.
  - If idx2 is invalid, diff = saturated max1 - init.
- OUT cycle:
  - Register o_diff, o_max_idx, o_2nd_idx and o_conf; pulse o_validp.
  - Latency: last beat registered at edge t -> o_validp high in cycle t+2.
- Voting, evaluated in the OUT cycle:
  - If o_conf is 0 or idx1 is invalid: run = 0.
  - Else if idx1 == candidate: run = min(run+1, HOLD_N).
  - Else: candidate = idx1, run = 1.
  - When run reaches HOLD_N and candidate != o_stable_idx: o_stable_idx <- candidate, with o_stable_chg pulsing coincident with o_validp.
  - o_stable_idx never returns to invalid except by reset.
- Reset asserted mid-frame: all state returns to reset values immediately; no pulse outputs.

Decomposition:
- Package signdet_pkg:
  - FSM state enum (IDLE/ACC/EVAL/OUT).
  - Invalid-index constant function of IW.
  - Saturating-subtract helper function.
- One sub-module, signdet_top2_tracker: holds max1/max2/idx1/idx2, with parameters DW/IW/SIGNED_CMP and clear/we/data/index inputs.
- Voting and FSM live in the top level.

Test Plan:
- Unsigned, th=100:
  - Stimulus: init, scores 5,300,20,150,0,7,9,1.
  - Response: o_max_idx=1, o_2nd_idx=3, o_diff=150, o_conf=1, o_validp 2 cycles after the last beat.
- Unsigned, negatives:
  - Stimulus: all 8 scores 0x8000+.
  - Response: o_max_idx=o_2nd_idx=15, o_diff=0, o_conf=0, stable index unchanged.
- SIGNED_CMP=1:
  - Stimulus: scores -5,-2,-9,... (all negative, -2 unique max, -5 second).
  - Response: o_max_idx=1, o_2nd_idx=0, o_diff=3.
  - Stimulus: max 0x7FFF with all other scores 0x8000.
  - Response: o_diff saturates to 0xFFFF.
- Tie:
  - Stimulus: scores 200 at indices 2 and 5, th=1.
  - Response: o_max_idx=2, o_2nd_idx=5, o_diff=0, o_conf=0.
- Voting, HOLD_N=3:
  - Stimulus: confident frames with top index 4,4,2,4,4,4.
  - Response: o_stable_chg only on the 6th frame, with o_stable_idx=4.
  - Stimulus: a low-confidence frame inserted mid-run.
  - Response: run restarts.
- Abort:
  - Stimulus: init, 3 beats, init with simultaneous i_we, then 8 beats.
  - Response: one o_abort pulse; the dropped beat is not counted; the single o_validp reflects only the final 8 scores.

Source files
------------

// File: rtl/signdet_pkg.sv
// Shared types and helpers for the sign/gesture classifier post-vote slice.
package signdet_pkg;

  typedef enum logic [1:0] {StIdle, StAcc, StEval, StOut} vote_state_e;

  function automatic int unsigned inv_idx(input int unsigned iw);
    return (32'd1 << iw) - 32'd1;
  endfunction

  // a - b clamped to the range [0, 2**dw-1].
  function automatic logic [63:0] sat_sub(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int unsigned dw);
    logic signed [63:0] d;
    logic [63:0]        lim;
    d   = a - b;
    lim = (64'd1 << dw) - 64'd1;
    if (d < 0) return '0;
    if ($unsigned(d) > lim) return lim;
    return $unsigned(d);
  endfunction

endpackage

// File: rtl/signdet_top2_tracker.sv
// Running top-2 score/index tracker; strict compares so the earliest index wins ties.
module signdet_top2_tracker
  import signdet_pkg::*;
#(
  parameter int unsigned DW         = 16,
  parameter int unsigned IW         = 4,
  parameter int unsigned SIGNED_CMP = 0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          we,
  input  logic [DW-1:0] data,
  input  logic [IW-1:0] idx,
  output logic [DW-1:0] max1,
  output logic [DW-1:0] max2,
  output logic [IW-1:0] idx1,
  output logic [IW-1:0] idx2
);

  localparam logic [IW-1:0] InvIdx  = IW'(inv_idx(IW));
  localparam logic [DW-1:0] InitVal = (SIGNED_CMP != 0) ? (DW'(1) << (DW - 1)) : DW'(0);

  logic [DW-1:0] max1_q, max1_d, max2_q, max2_d;
  logic [IW-1:0] idx1_q, idx1_d, idx2_q, idx2_d;
  logic          elig, gt1, gt2;

  always_comb begin
    if (SIGNED_CMP != 0) begin
      gt1  = $signed(data) > $signed(max1_q);
      gt2  = $signed(data) > $signed(max2_q);
      elig = we;
    end else begin
      gt1  = data > max1_q;
      gt2  = data > max2_q;
      // MSB-set scores are out of range in unsigned mode
      elig = we && !data[DW-1];
    end
  end

  always_comb begin
    max1_d = max1_q;
    max2_d = max2_q;
    idx1_d = idx1_q;
    idx2_d = idx2_q;
    if (clr) begin
      max1_d = InitVal;
      max2_d = InitVal;
      idx1_d = InvIdx;
      idx2_d = InvIdx;
    end else if (elig) begin
      if (gt1) begin
        max2_d = max1_q;
        idx2_d = idx1_q;
        max1_d = data;
        idx1_d = idx;
      end else if (gt2) begin
        max2_d = data;
        idx2_d = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      max1_q <= InitVal;
      max2_q <= InitVal;
      idx1_q <= InvIdx;
      idx2_q <= InvIdx;
    end else begin
      max1_q <= max1_d;
      max2_q <= max2_d;
      idx1_q <= idx1_d;
      idx2_q <= idx2_d;
    end
  end

  assign max1 = max1_q;
  assign max2 = max2_q;
  assign idx1 = idx1_q;
  assign idx2 = idx2_q;

endmodule

// File: rtl/signdet_post_vote.sv
// Classifier post-processor: per-frame top-2 margin, confidence gate and N-frame voting.
module signdet_post_vote
  import signdet_pkg::*;
#(
  parameter int unsigned DW         = 16,
  parameter int unsigned NCLS       = 8,
  parameter int unsigned IW         = 4,
  parameter int unsigned SIGNED_CMP = 0,
  parameter int unsigned HOLD_N     = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_init,
  input  logic          i_we,
  input  logic [DW-1:0] i_dout,
  input  logic [DW-1:0] i_conf_th,
  output logic [DW-1:0] o_diff,
  output logic [IW-1:0] o_max_idx,
  output logic [IW-1:0] o_2nd_idx,
  output logic          o_conf,
  output logic          o_validp,
  output logic [IW-1:0] o_stable_idx,
  output logic          o_stable_chg,
  output logic          o_abort
);

  localparam logic [IW-1:0] InvIdx   = IW'(inv_idx(IW));
  localparam logic [IW-1:0] LastBeat = IW'(NCLS - 1);
  localparam int unsigned   RW       = $clog2(HOLD_N + 1);
  localparam logic [RW-1:0] RunMax   = RW'(HOLD_N);

  vote_state_e   state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] diff_q, diff_d;
  logic [IW-1:0] max_idx_q, max_idx_d, snd_idx_q, snd_idx_d;
  logic          conf_q, conf_d, validp_q, validp_d, chg_q, chg_d, abort_q, abort_d;
  logic [IW-1:0] stable_q, stable_d, cand_q, cand_d;
  logic [RW-1:0] run_q, run_d;

  logic          beat_acc;
  logic [DW-1:0] max1, max2, diff_eval;
  logic [IW-1:0] idx1, idx2;
  logic          conf_eval;
  logic signed [63:0] ext1, ext2;

  signdet_top2_tracker #(
    .DW        (DW),
    .IW        (IW),
    .SIGNED_CMP(SIGNED_CMP)
  ) u_tracker (
    .clk   (clk),
    .resetn(resetn),
    .clr   (i_init),
    .we    (beat_acc),
    .data  (i_dout),
    .idx   (cnt_q),
    .max1  (max1),
    .max2  (max2),
    .idx1  (idx1),
    .idx2  (idx2)
  );

  // An untouched max2 still holds the init value, so max1 - max2 covers the invalid-idx2 case.
  always_comb begin
    if (SIGNED_CMP != 0) begin
      ext1 = 64'($signed(max1));
      ext2 = 64'($signed(max2));
    end else begin
      ext1 = 64'(max1);
      ext2 = 64'(max2);
    end
    diff_eval = DW'(sat_sub(ext1, ext2, DW));
    conf_eval = (diff_eval >= i_conf_th) && (idx1 != InvIdx);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    diff_d    = diff_q;
    max_idx_d = max_idx_q;
    snd_idx_d = snd_idx_q;
    conf_d    = conf_q;
    stable_d  = stable_q;
    cand_d    = cand_q;
    run_d     = run_q;
    validp_d  = 1'b0;
    chg_d     = 1'b0;
    abort_d   = 1'b0;
    beat_acc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_init) begin
          state_d = StAcc;
          cnt_d   = '0;
        end
      end
      StAcc: begin
        if (i_init) begin
          cnt_d   = '0;
          abort_d = (cnt_q != '0);
        end else if (i_we) begin
          beat_acc = 1'b1;
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StEval;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StEval: begin
        state_d   = StOut;
        pend_d    = i_init;
        diff_d    = diff_eval;
        max_idx_d = idx1;
        snd_idx_d = idx2;
        conf_d    = conf_eval;
        validp_d  = 1'b1;
        if (!conf_eval) begin
          run_d = '0;
        end else if (idx1 == cand_q) begin
          run_d = (run_q >= RunMax) ? RunMax : run_q + 1'b1;
        end else begin
          cand_d = idx1;
          run_d  = RW'(1);
        end
        if (run_d == RunMax && cand_d != stable_q) begin
          stable_d = cand_d;
          chg_d    = 1'b1;
        end
      end
      StOut: begin
        state_d = (i_init || pend_q) ? StAcc : StIdle;
        pend_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      diff_q    <= '0;
      max_idx_q <= InvIdx;
      snd_idx_q <= InvIdx;
      conf_q    <= 1'b0;
      validp_q  <= 1'b0;
      stable_q  <= InvIdx;
      chg_q     <= 1'b0;
      abort_q   <= 1'b0;
      cand_q    <= InvIdx;
      run_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      diff_q    <= diff_d;
      max_idx_q <= max_idx_d;
      snd_idx_q <= snd_idx_d;
      conf_q    <= conf_d;
      validp_q  <= validp_d;
      stable_q  <= stable_d;
      chg_q     <= chg_d;
      abort_q   <= abort_d;
      cand_q    <= cand_d;
      run_q     <= run_d;
    end
  end

  assign o_diff       = diff_q;
  assign o_max_idx    = max_idx_q;
  assign o_2nd_idx    = snd_idx_q;
  assign o_conf       = conf_q;
  assign o_validp     = validp_q;
  assign o_stable_idx = stable_q;
  assign o_stable_chg = chg_q;
  assign o_abort      = abort_q;

endmodule

// File: tb/tb_signdet_post_vote.sv
// Randomised bench: unsigned and signed instances checked every cycle against a frame-level model.
module tb_signdet_post_vote;

  localparam int NCLS   = 8;
  localparam int HOLD_N = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_init = 1'b0, i_we = 1'b0;
  logic [15:0] i_dout = '0, i_conf_th = '0;

  logic [15:0] u_diff, s_diff;
  logic [3:0]  u_mi, u_si, u_st, s_mi, s_si, s_st;
  logic        u_conf, u_vp, u_chg, u_ab, s_conf, s_vp, s_chg, s_ab;

  always #5 clk = ~clk;

  signdet_post_vote #(.DW(16), .NCLS(NCLS), .IW(4), .SIGNED_CMP(0), .HOLD_N(HOLD_N)) u_uns (
    .clk(clk), .resetn(resetn), .i_init(i_init), .i_we(i_we), .i_dout(i_dout),
    .i_conf_th(i_conf_th), .o_diff(u_diff), .o_max_idx(u_mi), .o_2nd_idx(u_si),
    .o_conf(u_conf), .o_validp(u_vp), .o_stable_idx(u_st), .o_stable_chg(u_chg),
    .o_abort(u_ab)
  );

  signdet_post_vote #(.DW(16), .NCLS(NCLS), .IW(4), .SIGNED_CMP(1), .HOLD_N(HOLD_N)) u_sgn (
    .clk(clk), .resetn(resetn), .i_init(i_init), .i_we(i_we), .i_dout(i_dout),
    .i_conf_th(i_conf_th), .o_diff(s_diff), .o_max_idx(s_mi), .o_2nd_idx(s_si),
    .o_conf(s_conf), .o_validp(s_vp), .o_stable_idx(s_st), .o_stable_chg(s_chg),
    .o_abort(s_ab)
  );

  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- frame-level model (index 0 = unsigned, 1 = signed) ----------------
  int     m_open, m_post, m_pend;
  longint m_q[$], m_frame[$];
  int     e_diff[2], e_i1[2], e_i2[2], e_conf[2], e_vp[2], e_st[2], e_chg[2], e_ab[2];
  int     cand[2], run[2];

  task automatic model_reset();
    m_open = 0; m_post = 0; m_pend = 0;
    m_q.delete();
    for (int m = 0; m < 2; m++) begin
      e_diff[m] = 0; e_i1[m] = 15; e_i2[m] = 15; e_conf[m] = 0; e_vp[m] = 0;
      e_st[m] = 15; e_chg[m] = 0; e_ab[m] = 0; cand[m] = 15; run[m] = 0;
    end
  endtask

  function automatic void eval_frame(input int m, input int th, output int i1, output int i2,
                                     output int d, output int c);
    longint v[NCLS];
    bit     el[NCLS];
    longint init, dl;
    init = (m == 1) ? -32768 : 0;
    for (int k = 0; k < NCLS; k++) begin
      longint raw = m_frame[k];
      v[k]  = (m == 1 && raw >= 32768) ? raw - 65536 : raw;
      el[k] = (v[k] > init) && (m == 1 || raw < 32768);
    end
    i1 = 15;
    for (int k = 0; k < NCLS; k++) if (el[k] && (i1 == 15 || v[k] > v[i1])) i1 = k;
    i2 = 15;
    for (int k = 0; k < NCLS; k++)
      if (el[k] && k != i1 && (i2 == 15 || v[k] > v[i2])) i2 = k;
    if (i1 == 15) dl = 0;
    else dl = v[i1] - ((i2 == 15) ? init : v[i2]);
    if (dl > 65535) dl = 65535;
    d = int'(dl);
    c = (i1 != 15 && dl >= th) ? 1 : 0;
  endfunction

  task automatic model_step();
    int i1, i2, d, c;
    for (int m = 0; m < 2; m++) begin e_vp[m] = 0; e_chg[m] = 0; e_ab[m] = 0; end
    if (m_post == 1) begin
      for (int m = 0; m < 2; m++) begin
        eval_frame(m, int'(i_conf_th), i1, i2, d, c);
        e_diff[m] = d; e_i1[m] = i1; e_i2[m] = i2; e_conf[m] = c; e_vp[m] = 1;
        if (c == 0) run[m] = 0;
        else if (i1 == cand[m]) begin if (run[m] < HOLD_N) run[m]++; end
        else begin cand[m] = i1; run[m] = 1; end
        if (run[m] == HOLD_N && cand[m] != e_st[m]) begin e_st[m] = cand[m]; e_chg[m] = 1; end
      end
      m_post = 2;
      m_pend = int'(i_init);
    end else if (m_post == 2) begin
      m_post = 0;
      if (i_init || m_pend != 0) begin m_open = 1; m_q.delete(); end
      m_pend = 0;
    end else if (i_init) begin
      if (m_open != 0 && m_q.size() > 0) begin e_ab[0] = 1; e_ab[1] = 1; end
      m_open = 1;
      m_q.delete();
    end else if (m_open != 0 && i_we) begin
      m_q.push_back(longint'(i_dout));
      if (m_q.size() == NCLS) begin
        m_frame = m_q; m_q.delete(); m_open = 0; m_post = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic chk_out(input string t, input int m, input int diff, input int mi, input int si,
                         input int conf, input int vp, input int st, input int chg, input int ab);
    chk({t, ".diff"}, diff, e_diff[m]);
    chk({t, ".max_idx"}, mi, e_i1[m]);
    chk({t, ".2nd_idx"}, si, e_i2[m]);
    chk({t, ".conf"}, conf, e_conf[m]);
    chk({t, ".validp"}, vp, e_vp[m]);
    chk({t, ".stable_idx"}, st, e_st[m]);
    chk({t, ".stable_chg"}, chg, e_chg[m]);
    chk({t, ".abort"}, ab, e_ab[m]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk_out("uns", 0, u_diff, u_mi, u_si, u_conf, u_vp, u_st, u_chg, u_ab);
      chk_out("sgn", 1, s_diff, s_mi, s_si, s_conf, s_vp, s_st, s_chg, s_ab);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit init, input bit we, input logic [15:0] d);
    @(negedge clk);
    i_init = init; i_we = we; i_dout = d;
  endtask

  // Leaves the caller at the cycle where o_validp must be high.
  task automatic frame8(input logic [15:0] sc[NCLS], input bit gaps);
    cyc(1, 0, 0);
    for (int k = 0; k < NCLS; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) cyc(0, 0, 16'($urandom));
      cyc(0, 1, sc[k]);
    end
    cyc(0, 0, 0);
    chk("lat.early_validp", u_vp, 0);
    cyc(0, 0, 0);
    chk("lat.validp", u_vp, 1);
  endtask

  task automatic vframe(input int top, input bit confident);
    logic [15:0] sc[NCLS];
    for (int k = 0; k < NCLS; k++) sc[k] = 16'd50;
    sc[top] = confident ? 16'd1000 : 16'd120;
    frame8(sc, 0);
  endtask

  task automatic rand_score(output logic [15:0] v);
    case ($urandom_range(0, 3))
      0: v = 16'($urandom_range(0, 15) * 50);
      1: v = 16'($urandom);
      2: v = 16'h8000 | 16'($urandom_range(0, 7));
      default: v = 16'h7FF0 + 16'($urandom_range(0, 15));
    endcase
  endtask

  initial begin
    logic [15:0] sc[NCLS];
    logic [15:0] v;
    int          tops[6];
    int          r;

    repeat (3) @(negedge clk);
    chk("rst.diff", u_diff, 0);
    chk("rst.max_idx", u_mi, 15);
    chk("rst.stable_idx", s_st, 15);
    chk("rst.validp", u_vp, 0);
    chk_en = 1;
    resetn = 1'b1;

    // Unsigned basic, th=100
    i_conf_th = 16'd100;
    sc = '{16'd5, 16'd300, 16'd20, 16'd150, 16'd0, 16'd7, 16'd9, 16'd1};
    frame8(sc, 1);
    chk("t1.max_idx", u_mi, 1);
    chk("t1.2nd_idx", u_si, 3);
    chk("t1.diff", u_diff, 150);
    chk("t1.conf", u_conf, 1);

    // All MSB-set scores in unsigned mode
    for (int k = 0; k < NCLS; k++) sc[k] = 16'h8000 + 16'(k);
    frame8(sc, 0);
    chk("neg.max_idx", u_mi, 15);
    chk("neg.2nd_idx", u_si, 15);
    chk("neg.diff", u_diff, 0);
    chk("neg.conf", u_conf, 0);
    chk("neg.stable_idx", u_st, 15);

    // Signed, all negative
    sc = '{16'hFFFB, 16'hFFFE, 16'hFFF7, 16'hFFF6, 16'hFFF5, 16'hFFF4, 16'hFFF3, 16'hFFF2};
    frame8(sc, 1);
    chk("sgn.max_idx", s_mi, 1);
    chk("sgn.2nd_idx", s_si, 0);
    chk("sgn.diff", s_diff, 3);

    // Signed full-range margin
    for (int k = 0; k < NCLS; k++) sc[k] = 16'h8000;
    sc[0] = 16'h7FFF;
    frame8(sc, 0);
    chk("sat.diff", s_diff, 16'hFFFF);
    chk("sat.2nd_idx", s_si, 15);
    chk("sat.uns_diff", u_diff, 16'h7FFF);

    // Tie at indices 2 and 5
    i_conf_th = 16'd1;
    sc = '{16'd10, 16'd11, 16'd200, 16'd12, 16'd13, 16'd200, 16'd14, 16'd15};
    frame8(sc, 0);
    chk("tie.max_idx", u_mi, 2);
    chk("tie.2nd_idx", u_si, 5);
    chk("tie.diff", u_diff, 0);
    chk("tie.conf", u_conf, 0);

    // Reset asserted mid-frame
    vframe(6, 1);
    cyc(1, 0, 0);
    repeat (3) cyc(0, 1, 16'd500);
    #2;
    resetn = 1'b0; i_init = 1'b0; i_we = 1'b0;
    #1;
    chk("rstmid.stable_idx", u_st, 15);
    chk("rstmid.max_idx", u_mi, 15);
    chk("rstmid.diff", u_diff, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Voting: 4,4,2,4,4,4
    i_conf_th = 16'd100;
    tops = '{4, 4, 2, 4, 4, 4};
    for (int f = 0; f < 6; f++) begin
      vframe(tops[f], 1);
      chk("vote.chg", u_chg, (f == 5) ? 1 : 0);
    end
    chk("vote.stable_idx", u_st, 4);

    // Low-confidence frame restarts the run
    for (int f = 0; f < 6; f++) begin
      vframe(6, f != 2);
      chk("vote2.chg", s_chg, (f == 5) ? 1 : 0);
    end
    chk("vote2.stable_idx", s_st, 6);

    // Abort: init, 3 beats, init with a simultaneous beat, then 8 beats
    cyc(1, 0, 0);
    repeat (3) cyc(0, 1, 16'd999);
    cyc(1, 1, 16'd5000);
    cyc(0, 1, 16'd10);
    chk("abort.pulse", u_ab, 1);
    for (int k = 1; k < NCLS; k++) begin
      cyc(0, 1, 16'(10 * (k + 1)));
      chk("abort.single", u_ab, 0);
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("abort.validp", u_vp, 1);
    chk("abort.max_idx", u_mi, 7);
    chk("abort.2nd_idx", u_si, 6);
    chk("abort.diff", u_diff, 10);

    // Randomised traffic, including init during EVAL/OUT and stray resets
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) i_conf_th = 16'($urandom_range(0, 400));
      if ($urandom_range(0, 599) == 0) begin
        @(negedge clk);
        #2;
        resetn = 1'b0; i_init = 1'b0; i_we = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
      end else if (r < 6) begin
        cyc(1, $urandom_range(0, 1) == 1, 16'($urandom));
      end else if (r < 75) begin
        rand_score(v);
        cyc(0, 1, v);
      end else begin
        cyc(0, 0, 16'($urandom));
      end
    end
    cyc(0, 0, 0);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
